// File: rtl/x86_decode_pkg.sv
// Shared types and constants for the x86 byte-serial opcode scanner.
package x86_decode_pkg;

    typedef enum logic [2:0] {
        SEG_NONE = 3'd0,
        SEG_ES   = 3'd1,
        SEG_CS   = 3'd2,
        SEG_SS   = 3'd3,
        SEG_DS   = 3'd4,
        SEG_FS   = 3'd5,
        SEG_GS   = 3'd6
    } seg_e;

    typedef enum logic [1:0] {
        MAP_ONE  = 2'd0,
        MAP_0F   = 2'd1,
        MAP_0F38 = 2'd2,
        MAP_0F3A = 2'd3
    } opmap_e;

    typedef enum logic [2:0] {
        PREFIX = 3'd0,
        ESC    = 3'd1,
        ESC3   = 3'd2,
        MODRM  = 3'd3,
        EMIT   = 3'd4
    } scan_state_e;

    // Field order matches the out_prefix bus: {lock, rep, repne, opsize, addrsize, seg, rex(WRXB)}.
    typedef struct packed {
        logic       lock;
        logic       rep;
        logic       repne;
        logic       opsize;
        logic       addrsize;
        seg_e       seg;
        logic [3:0] rex;
    } prefix_t;

    localparam logic [7:0] ESC_0F = 8'h0F;
    localparam logic [7:0] ESC_38 = 8'h38;
    localparam logic [7:0] ESC_3A = 8'h3A;

endpackage

// File: rtl/x86_opcode_scanner_if.sv
// Byte-in / header-out stream bundle between fetch, scanner and operand stage.
interface x86_opcode_scanner_if
    import x86_decode_pkg::*;
;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    logic       out_valid;
    logic       out_ready;
    prefix_t    out_prefix;
    opmap_e     out_map;
    logic [7:0] out_opcode;
    logic       out_modrm_v;
    logic [7:0] out_modrm;
    logic [3:0] out_len;
    logic       out_err;

    // Byte source and header consumer side.
    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_prefix, out_map, out_opcode,
               out_modrm_v, out_modrm, out_len, out_err
    );

    // Scanner side.
    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_prefix, out_map, out_opcode,
               out_modrm_v, out_modrm, out_len, out_err
    );
endinterface

// File: rtl/x86_prefix_classify.sv
// Combinational classifier: decides whether a byte is a legacy or REX prefix
// and computes the prefix record that results from absorbing it.
module x86_prefix_classify
    import x86_decode_pkg::*;
#(
    parameter bit LONG_MODE = 1'b1
) (
    input  logic [7:0] byte_i,
    input  prefix_t    prefix_i,
    output logic       is_legacy,
    output logic       is_rex,
    output prefix_t    prefix_o
);

    // Classify the byte and fold it into the running prefix record.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        is_legacy = 1'b1;
        is_rex    = 1'b0;
        prefix_o  = prefix_i;
        case (byte_i)
            8'hF0: prefix_o.lock = 1'b1;
            8'hF2: begin
                prefix_o.repne = 1'b1;
                prefix_o.rep   = 1'b0;
            end
            8'hF3: begin
                prefix_o.rep   = 1'b1;
                prefix_o.repne = 1'b0;
            end
            8'h66: prefix_o.opsize   = 1'b1;
            8'h67: prefix_o.addrsize = 1'b1;
            8'h26: prefix_o.seg      = SEG_ES;
            8'h2E: prefix_o.seg      = SEG_CS;
            8'h36: prefix_o.seg      = SEG_SS;
            8'h3E: prefix_o.seg      = SEG_DS;
            8'h64: prefix_o.seg      = SEG_FS;
            8'h65: prefix_o.seg      = SEG_GS;
            default: is_legacy = 1'b0;
        endcase
        // REX only counts when it sits directly in front of the opcode, so a
        // later legacy prefix voids any REX seen earlier.
        if (is_legacy) begin
            prefix_o.rex = 4'h0;
        end else if (LONG_MODE && (byte_i[7:4] == 4'h4)) begin
            is_rex       = 1'b1;
            prefix_o.rex = byte_i[3:0];
        end
    end

endmodule

// File: rtl/x86_opcode_scanner.sv
// Byte-serial x86 front end: absorbs prefixes, resolves escape maps, captures
// opcode and ModRM, and presents one header per instruction.
module x86_opcode_scanner
    import x86_decode_pkg::*;
#(
    parameter int MAX_LEN   = 15,
    parameter bit LONG_MODE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [255:0]         modrm1_map,
    input  logic [255:0]         modrm2_map,
    x86_opcode_scanner_if.slave  bus
);

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    scan_state_e state_q, state_d;
    prefix_t     prefix_q, prefix_d;
    opmap_e      map_q, map_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        modrm_v_q, modrm_v_d;
    logic [7:0]  modrm_q, modrm_d;
    logic [3:0]  len_q, len_d;
    logic        err_q, err_d;

    logic        accept;
    logic        cls_is_legacy;
    logic        cls_is_rex;
    prefix_t     cls_prefix;

    x86_prefix_classify #(
        .LONG_MODE (LONG_MODE)
    ) u_classify (
        .byte_i    (bus.in_byte),
        .prefix_i  (prefix_q),
        .is_legacy (cls_is_legacy),
        .is_rex    (cls_is_rex),
        .prefix_o  (cls_prefix)
    );

    assign accept = bus.in_valid && (state_q != EMIT);

    // Next-state and header-field updates for each accepted byte or EMIT handshake.
    always_comb begin
        state_d   = state_q;
        prefix_d  = prefix_q;
        map_d     = map_q;
        opcode_d  = opcode_q;
        modrm_v_d = modrm_v_q;
        modrm_d   = modrm_q;
        len_d     = len_q;
        err_d     = err_q;

        if (accept) begin
            len_d = len_q + 4'd1;
            unique case (state_q)
                PREFIX: begin
                    if (cls_is_legacy || cls_is_rex) begin
                        prefix_d = cls_prefix;
                    end else if (bus.in_byte == ESC_0F) begin
                        state_d = ESC;
                    end else begin
                        map_d    = MAP_ONE;
                        opcode_d = bus.in_byte;
                        state_d  = modrm1_map[bus.in_byte] ? MODRM : EMIT;
                    end
                end
                ESC: begin
                    if (bus.in_byte == ESC_38) begin
                        map_d   = MAP_0F38;
                        state_d = ESC3;
                    end else if (bus.in_byte == ESC_3A) begin
                        map_d   = MAP_0F3A;
                        state_d = ESC3;
                    end else begin
                        map_d    = MAP_0F;
                        opcode_d = bus.in_byte;
                        state_d  = modrm2_map[bus.in_byte] ? MODRM : EMIT;
                    end
                end
                ESC3: begin
                    opcode_d = bus.in_byte;
                    state_d  = MODRM;
                end
                MODRM: begin
                    modrm_d   = bus.in_byte;
                    modrm_v_d = 1'b1;
                    state_d   = EMIT;
                end
                default: ;
            endcase
            // Running out of length budget mid-header forces an error header;
            // upstream flushes the rest of the instruction.
            if ((len_d == MAX_LEN_L) && (state_d != EMIT)) begin
                state_d = EMIT;
                err_d   = 1'b1;
            end
        end else if ((state_q == EMIT) && bus.out_ready) begin
            state_d   = PREFIX;
            prefix_d  = '0;
            map_d     = MAP_ONE;
            opcode_d  = 8'h00;
            modrm_v_d = 1'b0;
            modrm_d   = 8'h00;
            len_d     = 4'd0;
            err_d     = 1'b0;
        end
    end

    // State and header registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from the previous cycle's values.
        if (reset) begin
            state_q   <= PREFIX;
            prefix_q  <= '0;
            map_q     <= MAP_ONE;
            opcode_q  <= 8'h00;
            modrm_v_q <= 1'b0;
            modrm_q   <= 8'h00;
            len_q     <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prefix_q  <= prefix_d;
            map_q     <= map_d;
            opcode_q  <= opcode_d;
            modrm_v_q <= modrm_v_d;
            modrm_q   <= modrm_d;
            len_q     <= len_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready    = (state_q != EMIT);
    assign bus.out_valid   = (state_q == EMIT);
    assign bus.out_prefix  = prefix_q;
    assign bus.out_map     = map_q;
    assign bus.out_opcode  = opcode_q;
    assign bus.out_modrm_v = modrm_v_q;
    assign bus.out_modrm   = modrm_q;
    assign bus.out_len     = len_q;
    assign bus.out_err     = err_q;

endmodule

// File: tb/tb_x86_opcode_scanner.sv
// Self-checking bench for x86_opcode_scanner: directed cases plus randomized
// instructions checked against a byte-list parsing model.
module tb_x86_opcode_scanner;
    import x86_decode_pkg::*;

    localparam int MAX_LEN = 15;

    typedef struct packed {
        logic [11:0] prefix;
        logic [1:0]  map;
        logic [7:0]  opcode;
        logic        modrm_v;
        logic [7:0]  modrm;
        logic [3:0]  len;
        logic        err;
    } hdr_t;

    logic         clk;
    logic         reset;
    logic [255:0] modrm1_map;
    logic [255:0] modrm2_map;
    int           checks;
    int           errors;

    logic [7:0] legacy_tab [11] = '{8'hF0, 8'hF2, 8'hF3, 8'h66, 8'h67,
                                    8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};

    x86_opcode_scanner_if bus ();

    x86_opcode_scanner #(
        .MAX_LEN   (MAX_LEN),
        .LONG_MODE (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .modrm1_map (modrm1_map),
        .modrm2_map (modrm2_map),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1);
    end

    function automatic hdr_t sample();
        hdr_t h;
        h.prefix  = bus.out_prefix;
        h.map     = bus.out_map;
        h.opcode  = bus.out_opcode;
        h.modrm_v = bus.out_modrm_v;
        h.modrm   = bus.out_modrm;
        h.len     = bus.out_len;
        h.err     = bus.out_err;
        return h;
    endfunction

    function automatic string fmt(input hdr_t h);
        return $sformatf("pfx=%03h map=%0d op=%02h mv=%b modrm=%02h len=%0d err=%b",
                         h.prefix, h.map, h.opcode, h.modrm_v, h.modrm, h.len, h.err);
    endfunction

    function automatic bit is_prefix(input logic [7:0] x);
        if (x[7:4] == 4'h4) return 1'b1;
        foreach (legacy_tab[i]) if (legacy_tab[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: parse the whole byte list the way the instruction format reads.
    function automatic hdr_t model_header(input logic [7:0] b[$]);
        hdr_t       h;
        int         pos;
        logic       lock, rep, repne, os, as_, last_rex;
        logic [2:0] seg;
        logic [3:0] rex_val;
        logic       need;
        h = '0;
        {lock, rep, repne, os, as_, last_rex} = '0;
        seg = 3'd0;
        rex_val = 4'h0;
        need = 1'b0;
        pos = 0;
        while (pos < b.size() && is_prefix(b[pos]) && !h.err) begin
            last_rex = (b[pos][7:4] == 4'h4);
            if (last_rex) rex_val = b[pos][3:0];
            case (b[pos])
                8'hF0: lock = 1'b1;
                8'hF2: begin repne = 1'b1; rep = 1'b0; end
                8'hF3: begin rep = 1'b1; repne = 1'b0; end
                8'h66: os = 1'b1;
                8'h67: as_ = 1'b1;
                8'h26: seg = 3'd1;
                8'h2E: seg = 3'd2;
                8'h36: seg = 3'd3;
                8'h3E: seg = 3'd4;
                8'h64: seg = 3'd5;
                8'h65: seg = 3'd6;
                default: ;
            endcase
            pos++;
            if (pos == MAX_LEN) h.err = 1'b1;
        end
        if (!h.err) begin
            if (b[pos] == 8'h0F) begin
                if (b[pos+1] == 8'h38 || b[pos+1] == 8'h3A) begin
                    h.map    = (b[pos+1] == 8'h38) ? 2'd2 : 2'd3;
                    h.opcode = b[pos+2];
                    need     = 1'b1;
                    pos      = pos + 3;
                end else begin
                    h.map    = 2'd1;
                    h.opcode = b[pos+1];
                    need     = modrm2_map[b[pos+1]];
                    pos      = pos + 2;
                end
            end else begin
                h.map    = 2'd0;
                h.opcode = b[pos];
                need     = modrm1_map[b[pos]];
                pos      = pos + 1;
            end
            if (need) begin
                h.modrm_v = 1'b1;
                h.modrm   = b[pos];
                pos++;
            end
        end
        h.len    = 4'(pos);
        h.prefix = {lock, rep, repne, os, as_, seg, (last_rex ? rex_val : 4'h0)};
        return h;
    endfunction

    // Drive one instruction, capture its header, hold it for 'hold' cycles,
    // then take it. 'why' names the first handshake-protocol problem seen.
    task automatic send(input logic [7:0] b[$], input bit gaps, input int hold,
                        output hdr_t got, output string why);
        int k;
        why = "";
        k = 0;
        while (k < b.size()) begin
            @(negedge clk);
            if ((bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) && why == "")
                why = "valid_early_or_not_ready";
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_byte  = b[k];
                k++;
            end
        end
        @(negedge clk);
        // Offer a junk prefix byte during EMIT; it must not be consumed.
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h66;
        got = sample();
        if (bus.out_valid !== 1'b1 && why == "") why = "no_valid_after_last_byte";
        if (bus.in_ready !== 1'b0 && why == "") why = "in_ready_high_in_emit";
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if ((sample() !== got || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) && why == "")
                why = "header_not_stable_under_backpressure";
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        if ((bus.out_valid !== 1'b0 || sample() !== '0) && why == "")
            why = "header_not_cleared_after_handshake";
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
        end
        checks++;
        if (sample() !== '0) begin
            errors++;
            $display("FAIL reset_header: got %s exp all zero", fmt(sample()));
        end
        reset = 1'b0;
    endtask

    task automatic test_rex_modrm();
        hdr_t got, exp;
        string why;
        exp = '{prefix: 12'h008, map: 2'd0, opcode: 8'h89, modrm_v: 1'b1,
                modrm: 8'hC3, len: 4'd3, err: 1'b0};
        send({8'h48, 8'h89, 8'hC3}, 1'b0, 0, got, why);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rex_modrm: got %s exp %s", fmt(got), fmt(exp));
        end
        checks++;
        if (why != "") begin
            errors++;
            $display("FAIL rex_modrm_protocol: got %s exp clean handshake", why);
        end
    endtask

    task automatic test_two_byte();
        hdr_t got, exp;
        string why;
        exp = '{prefix: 12'h100, map: 2'd1, opcode: 8'hB6, modrm_v: 1'b1,
                modrm: 8'hC1, len: 4'd4, err: 1'b0};
        send({8'h66, 8'h0F, 8'hB6, 8'hC1}, 1'b1, 0, got, why);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL two_byte: got %s exp %s", fmt(got), fmt(exp));
        end
        checks++;
        if (why != "") begin
            errors++;
            $display("FAIL two_byte_protocol: got %s exp clean handshake", why);
        end
    endtask

    task automatic test_back_to_back_maps();
        hdr_t got, exp;
        string why;
        exp = '{prefix: 12'h000, map: 2'd1, opcode: 8'h05, modrm_v: 1'b0,
                modrm: 8'h00, len: 4'd2, err: 1'b0};
        send({8'h0F, 8'h05}, 1'b0, 0, got, why);
        checks++;
        if (got !== exp || why != "") begin
            errors++;
            $display("FAIL map_0f_no_modrm: got %s [%s] exp %s", fmt(got), why, fmt(exp));
        end
        exp = '{prefix: 12'h000, map: 2'd2, opcode: 8'h00, modrm_v: 1'b1,
                modrm: 8'hC8, len: 4'd4, err: 1'b0};
        send({8'h0F, 8'h38, 8'h00, 8'hC8}, 1'b0, 0, got, why);
        checks++;
        if (got !== exp || why != "") begin
            errors++;
            $display("FAIL map_0f38: got %s [%s] exp %s", fmt(got), why, fmt(exp));
        end
        exp = '{prefix: 12'h000, map: 2'd3, opcode: 8'h0F, modrm_v: 1'b1,
                modrm: 8'hD1, len: 4'd5, err: 1'b0};
        send({8'h4C, 8'h0F, 8'h3A, 8'h0F, 8'hD1}, 1'b0, 0, got, why);
        exp.prefix = 12'h00C;
        checks++;
        if (got !== exp || why != "") begin
            errors++;
            $display("FAIL map_0f3a_rex: got %s [%s] exp %s", fmt(got), why, fmt(exp));
        end
    endtask

    task automatic test_prefix_rules();
        hdr_t got, exp;
        string why;
        exp = '{prefix: 12'h100, map: 2'd0, opcode: 8'h90, modrm_v: 1'b0,
                modrm: 8'h00, len: 4'd3, err: 1'b0};
        send({8'h48, 8'h66, 8'h90}, 1'b0, 0, got, why);
        checks++;
        if (got !== exp || why != "") begin
            errors++;
            $display("FAIL rex_voided: got %s [%s] exp %s", fmt(got), why, fmt(exp));
        end
        exp.prefix = 12'h050;
        send({8'h2E, 8'h64, 8'h90}, 1'b0, 0, got, why);
        checks++;
        if (got !== exp || why != "") begin
            errors++;
            $display("FAIL last_seg_wins: got %s [%s] exp %s", fmt(got), why, fmt(exp));
        end
        exp.prefix = 12'hA00;
        exp.len    = 4'd4;
        send({8'hF3, 8'hF2, 8'hF0, 8'h90}, 1'b0, 0, got, why);
        checks++;
        if (got !== exp || why != "") begin
            errors++;
            $display("FAIL repne_over_rep_lock: got %s [%s] exp %s", fmt(got), why, fmt(exp));
        end
    endtask

    task automatic test_length_error();
        hdr_t got, exp;
        string why;
        logic [7:0] b[$];
        repeat (15) b.push_back(8'h66);
        exp = '{prefix: 12'h100, map: 2'd0, opcode: 8'h00, modrm_v: 1'b0,
                modrm: 8'h00, len: 4'd15, err: 1'b1};
        send(b, 1'b0, 1, got, why);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL length_error: got %s exp %s", fmt(got), fmt(exp));
        end
        checks++;
        if (why != "") begin
            errors++;
            $display("FAIL length_error_protocol: got %s exp clean handshake", why);
        end
    endtask

    task automatic test_backpressure();
        hdr_t got, exp;
        string why;
        exp = '{prefix: 12'h080, map: 2'd0, opcode: 8'h8B, modrm_v: 1'b1,
                modrm: 8'h45, len: 4'd3, err: 1'b0};
        send({8'h67, 8'h8B, 8'h45}, 1'b0, 3, got, why);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backpressure_header: got %s exp %s", fmt(got), fmt(exp));
        end
        checks++;
        if (why != "") begin
            errors++;
            $display("FAIL backpressure_protocol: got %s exp stable header, in_ready 0", why);
        end
    endtask

    task automatic test_reset_mid();
        hdr_t got, exp;
        string why;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h66;
        @(negedge clk);
        bus.in_byte  = 8'h0F;
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || sample() !== '0) begin
            errors++;
            $display("FAIL reset_mid_instr: got v=%b r=%b %s exp idle zero header",
                     bus.out_valid, bus.in_ready, fmt(sample()));
        end
        exp = '{prefix: 12'h000, map: 2'd0, opcode: 8'h90, modrm_v: 1'b0,
                modrm: 8'h00, len: 4'd1, err: 1'b0};
        send({8'h90}, 1'b0, 0, got, why);
        checks++;
        if (got !== exp || why != "") begin
            errors++;
            $display("FAIL after_reset_decode: got %s [%s] exp %s", fmt(got), why, fmt(exp));
        end
        // Reset while a header is waiting in EMIT.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h66;
        @(negedge clk);
        bus.in_byte  = 8'h90;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_emit_setup: got out_valid %b exp 1", bus.out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || sample() !== '0) begin
            errors++;
            $display("FAIL reset_in_emit: got v=%b r=%b %s exp idle zero header",
                     bus.out_valid, bus.in_ready, fmt(sample()));
        end
    endtask

    function automatic logic [7:0] rand_prefix();
        int idx;
        idx = $urandom_range(0, 26);
        if (idx < 11) return legacy_tab[idx];
        return 8'h40 + 8'(idx - 11);
    endfunction

    task automatic test_random();
        logic [7:0] b[$];
        logic [7:0] op;
        logic       need;
        hdr_t       got, exp;
        string      why;
        for (int n = 0; n < 60; n++) begin
            b.delete();
            repeat ($urandom_range(0, 4)) b.push_back(rand_prefix());
            need = 1'b1;
            case ($urandom_range(0, 3))
                0: begin
                    do op = 8'($urandom()); while (is_prefix(op) || op == 8'h0F);
                    b.push_back(op);
                    need = modrm1_map[op];
                end
                1: begin
                    do op = 8'($urandom()); while (op == 8'h38 || op == 8'h3A);
                    b.push_back(8'h0F);
                    b.push_back(op);
                    need = modrm2_map[op];
                end
                2: begin
                    b.push_back(8'h0F);
                    b.push_back(8'h38);
                    b.push_back(8'($urandom()));
                end
                default: begin
                    b.push_back(8'h0F);
                    b.push_back(8'h3A);
                    b.push_back(8'($urandom()));
                end
            endcase
            if (need) b.push_back(8'($urandom()));
            exp = model_header(b);
            send(b, 1'b1, $urandom_range(0, 2), got, why);
            checks++;
            if (got !== exp || why != "") begin
                errors++;
                $display("FAIL random_%0d: got %s [%s] exp %s", n, fmt(got), why, fmt(exp));
            end
        end
    endtask

    initial begin
        clk           = 1'b0;
        reset         = 1'b1;
        checks        = 0;
        errors        = 0;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            modrm1_map[i*32 +: 32] = $urandom();
            modrm2_map[i*32 +: 32] = $urandom();
        end
        modrm1_map[8'h89] = 1'b1;
        modrm1_map[8'h8B] = 1'b1;
        modrm1_map[8'h90] = 1'b0;
        modrm2_map[8'hB6] = 1'b1;
        modrm2_map[8'h05] = 1'b0;

        test_reset();
        test_rex_modrm();
        test_two_byte();
        test_back_to_back_maps();
        test_prefix_rules();
        test_length_error();
        test_backpressure();
        test_reset_mid();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/x86_opcode_scanner.md
# x86_opcode_scanner

Byte-serial front of the x86 decoder. It sits between the instruction-byte stream from the fetch buffer and the operand/immediate stages. It absorbs legacy and REX prefixes, resolves the 0F / 0F38 / 0F3A escape maps, and captures the opcode byte. Using the one-byte and two-byte ModRM-presence bitmaps supplied by the opcode tables, it also captures the ModRM byte and emits one decoded header per instruction. SIB, displacement and immediate bytes are left to the downstream stage.

## Interface
- `MAX_LEN`, 15: architectural instruction-length limit in bytes.
- `LONG_MODE`, 1: when 1, bytes 40–4F are REX prefixes; when 0, they are opcodes.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `modrm1_map` in 256: bit n set means one-byte opcode n takes ModRM.
- `modrm2_map` in 256: bit n set means 0F-map opcode n takes ModRM. This is the `ModRM2` vector from the two-byte opcode table.
- `in_valid` in 1: `in_byte` is valid.
- `in_byte` in 8: next instruction byte.
- `in_ready` out 1: scanner accepts `in_byte` this cycle.
- `out_valid` out 1: header valid.
- `out_ready` in 1: consumer takes the header.
- `out_prefix` out 12: {lock, rep, repne, opsize, addrsize, seg[2:0], rex[3:0]}, where rex is WRXB.
- `out_map` out 2: 0 = one-byte, 1 = 0F, 2 = 0F38, 3 = 0F3A.
- `out_opcode` out 8: opcode byte.
- `out_modrm_v` out 1: ModRM was consumed.
- `out_modrm` out 8: ModRM byte, or 0 when absent.
- `out_len` out 4: bytes consumed for this instruction, including the ModRM byte.
- `out_err` out 1: instruction exceeded `MAX_LEN` before its header completed.

## Operation
- States: PREFIX, ESC, ESC3, MODRM, EMIT. Reset enters PREFIX.
- Transfers:
  - A byte is accepted when `in_valid && in_ready`.
  - `in_ready` = 1 in PREFIX, ESC, ESC3 and MODRM; 0 in EMIT.
  - `out_valid` = 1 only in EMIT.
- PREFIX state, by accepted byte:
  - F0 sets lock.
  - F2 sets repne and clears rep.
  - F3 sets rep and clears repne.
  - 66 sets opsize.
  - 67 sets addrsize.
  - 26/2E/36/3E/64/65 set seg to 1/2/3/4/5/6 respectively; the last segment prefix wins.
  - 4x (when `LONG_MODE`) latches rex = x[3:0] and sets rex_pending.
  - Any legacy prefix after a REX clears rex to 0, because REX only counts when it is immediately before the opcode.
  - 0F goes to ESC.
  - Any other byte is the opcode with map 0. It then goes to MODRM if `modrm1_map[byte]`, else to EMIT.
- ESC state:
  - 38 goes to ESC3 with map 2; 3A goes to ESC3 with map 3.
  - Any other byte is the opcode with map 1. It then goes to MODRM if `modrm2_map[byte]`, else to EMIT.
- ESC3 state: the byte is the opcode, and the state always goes to MODRM.
- MODRM state: latches `out_modrm`, sets `out_modrm_v`, and goes to EMIT.
- Length counter: 4 bits, incremented on every accepted byte, and shown on `out_len`.
- Length error: if the `MAX_LEN`-th byte is accepted and the FSM's next state is not EMIT, go to EMIT with `out_err` = 1 and `out_len` = `MAX_LEN`. The remaining bytes of that instruction are not consumed; upstream flushes on err.
- On the EMIT handshake (`out_valid && out_ready`), all header registers clear and the FSM returns to PREFIX on the next cycle.

## Timing
- Reset values: all outputs 0, `in_ready` = 1 after the reset cycle, state PREFIX, counter 0.
- Throughput: one byte per cycle. `out_valid` rises in the cycle after the last header byte is accepted. The header occupies 1 EMIT cycle minimum and stays stable while `out_ready` is low.
- Gap: the first byte of the next instruction can be accepted in the cycle after the EMIT handshake, so there is one bubble per instruction.
- Gaps in `in_valid` stall the FSM with all state held.
- Map inputs: `modrm1_map` and `modrm2_map` are sampled combinationally in the cycle the opcode is accepted.
- `reset` asserted mid-instruction or during EMIT discards the partial header, and the next cycle behaves as after power-on reset.

## Structure
- Package `x86_decode_pkg` holds:
  - the `prefix_t` packed struct (12 bits, field order as above);
  - the `seg_e` enum (NONE, ES, CS, SS, DS, FS, GS);
  - the `opmap_e` enum (ONE, 0F, 0F38, 0F3A);
  - the `scan_state_e` enum;
  - constants `ESC_0F = 8'h0F`, `ESC_38 = 8'h38`, `ESC_3A = 8'h3A`.
- Sub-module `x86_prefix_classify`: a purely combinational byte classifier (is_legacy, is_rex, prefix field updates). It is instantiated once.

## Test plan
- `48 89 C3` with `modrm1_map[89]` = 1 → map 0, opcode 89, rex = 8, modrm_v = 1, modrm C3, len 3, err 0.
- `66 0F B6 C1` with `modrm2_map[B6]` = 1 → opsize = 1, map 1, opcode B6, modrm C1, len 4.
- `0F 05` with `modrm2_map[05]` = 0 → map 1, opcode 05, modrm_v = 0, len 2. Then `0F 38 00 C8` → map 2, opcode 00, modrm C8, len 4.
- `48 66 90` → rex = 0, opsize = 1, opcode 90, len 3. Also `2E 64 90` → seg = 5.
- 15 × `66` → `out_err` = 1, len 15, with the header emitted after the 15th byte.
- Hold `out_ready` low for 3 cycles in EMIT → outputs stable and `in_ready` = 0. Separately, assert `reset` after `66 0F` → the next `90` decodes with prefix = 0, map 0, len 1.
